// File: rtl/core_msg_rx_if.sv
// Scheduler-to-core message bus: one 16-bit word plus four loading strobes, with core_ready returned.
// The master drives the word and strobes; the slave (the core receiver) drives core_ready.
interface core_msg_rx_if #(
  parameter int BUS_TO_CORE = 16
);
  logic [BUS_TO_CORE-1:0] mess_to_core;
  logic                   core_mask_loading;
  logic                   r0_mask_loading;
  logic                   r0_loading;
  logic                   if_loading;
  logic                   core_ready;

  modport master (
    output mess_to_core, core_mask_loading, r0_mask_loading, r0_loading, if_loading,
    input  core_ready
  );

  modport slave (
    input  mess_to_core, core_mask_loading, r0_mask_loading, r0_loading, if_loading,
    output core_ready
  );
endinterface

// File: rtl/core_msg_rx.sv
// Per-core receiver: selection, r0 byte capture and instruction buffering for one task.
// Outputs registered except exec_start; ibuf_rdata 1-cycle read; no backpressure, core_ready is the only flow control.
module core_msg_rx #(
  parameter int CORE_ID     = 0,
  parameter int BUS_TO_CORE = 16,
  parameter int INSTR_SIZE  = 16,
  parameter int R0_DEPTH    = 8,
  parameter int IBUF_DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  core_msg_rx_if.slave                  sched,
  input  logic                          exec_done,
  input  logic [$clog2(IBUF_DEPTH)-1:0] ibuf_raddr,
  output logic [INSTR_SIZE-1:0]         ibuf_rdata,
  output logic                          selected,
  output logic [7:0]                    r0_value,
  output logic                          r0_valid,
  output logic [$clog2(IBUF_DEPTH):0]   prog_len,
  output logic                          exec_start,
  output logic                          ovf,
  output logic                          proto_err
);
  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int BW = $clog2(R0_DEPTH) + 1;
  localparam logic [BW-1:0] MY_BEAT = BW'(CORE_ID >> 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(R0_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(IBUF_DEPTH);
  localparam bit HI_BYTE = (CORE_ID % 2) == 1;

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_R0, S_IFL, S_RUN} state_e;

  state_e state_q, state_d;
  logic [BUS_TO_CORE-1:0] mess;
  logic cm, rm, r0l, ifl;
  logic s_rm, s_r0, s_if, any_strobe, multi_strobe, my_bit, take_mask;

  logic            selected_q, selected_d;
  logic [7:0]      r0_value_q, r0_value_d;
  logic            r0_valid_q, r0_valid_d;
  logic            r0_en_q, r0_en_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [AW:0]     prog_len_q, prog_len_d;
  logic            ovf_q, ovf_d;
  logic            proto_err_q, proto_err_d;
  logic            core_ready_q, core_ready_d;
  logic [INSTR_SIZE-1:0] rdata_q, rdata_d;
  logic            ibuf_we;
  logic [INSTR_SIZE-1:0] ibuf_mem [IBUF_DEPTH];

  assign mess = sched.mess_to_core;
  assign cm   = sched.core_mask_loading;
  assign rm   = sched.r0_mask_loading;
  assign r0l  = sched.r0_loading;
  assign ifl  = sched.if_loading;

  // Only the highest-priority strobe acts; any additional strobe is a protocol error.
  assign s_rm         = rm & ~cm;
  assign s_r0         = r0l & ~cm & ~rm;
  assign s_if         = ifl & ~cm & ~rm & ~r0l;
  assign any_strobe   = cm | rm | r0l | ifl;
  assign multi_strobe = (cm & (rm | r0l | ifl)) | (rm & (r0l | ifl)) | (r0l & ifl);
  assign my_bit       = mess[CORE_ID];
  assign take_mask    = cm & my_bit & ((state_q == S_IDLE) | (state_q == S_SEL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cm && my_bit) state_d = S_SEL;
      S_SEL: begin
        if (cm)        state_d = my_bit ? S_SEL : S_IDLE;
        else if (s_rm) state_d = S_R0;
        else if (s_if) state_d = S_IFL;
      end
      S_R0:  if (s_if) state_d = S_IFL;
      S_IFL: if (!ifl) state_d = S_RUN;
      S_RUN: if (exec_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exec_start = 1'b0;
    if ((state_q == S_IFL) && !ifl) exec_start = 1'b1;
  end

  always_comb begin
    selected_d   = selected_q;
    r0_value_d   = r0_value_q;
    r0_valid_d   = r0_valid_q;
    r0_en_d      = r0_en_q;
    beat_d       = beat_q;
    prog_len_d   = prog_len_q;
    ovf_d        = ovf_q;
    proto_err_d  = proto_err_q | multi_strobe;
    core_ready_d = core_ready_q;
    ibuf_we      = 1'b0;
    rdata_d      = ibuf_mem[ibuf_raddr];

    if (take_mask) begin
      selected_d = 1'b1;
      r0_valid_d = 1'b0;
      prog_len_d = '0;
    end
    if ((state_q == S_SEL) && cm && !my_bit) selected_d = 1'b0;
    if ((state_q == S_SEL) && s_rm) begin
      r0_en_d = my_bit;
      beat_d  = '0;
    end
    if ((state_q == S_R0) && s_r0) begin
      if (r0_en_q && (beat_q == MY_BEAT)) begin
        r0_value_d = HI_BYTE ? mess[15:8] : mess[7:0];
        r0_valid_d = 1'b1;
      end
      if (beat_q < LAST_BEAT) beat_d = beat_q + 1'b1;
    end
    // The buffer never wraps: once full, extra words are dropped and flagged.
    if (s_if && ((state_q == S_SEL) || (state_q == S_R0) || (state_q == S_IFL))) begin
      if (prog_len_q < FULL) begin
        ibuf_we    = 1'b1;
        prog_len_d = prog_len_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    case (state_q)
      S_SEL:   if (s_r0) proto_err_d = 1'b1;
      S_R0:    if (cm | s_rm) proto_err_d = 1'b1;
      S_IFL:   if (cm | s_rm | s_r0) proto_err_d = 1'b1;
      S_RUN:   if (any_strobe) proto_err_d = 1'b1;
      default: ;
    endcase
    if (exec_start) core_ready_d = 1'b0;
    if ((state_q == S_RUN) && exec_done) begin
      core_ready_d = 1'b1;
      selected_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      selected_q   <= 1'b0;
      r0_value_q   <= '0;
      r0_valid_q   <= 1'b0;
      r0_en_q      <= 1'b0;
      beat_q       <= '0;
      prog_len_q   <= '0;
      ovf_q        <= 1'b0;
      proto_err_q  <= 1'b0;
      core_ready_q <= 1'b1;
      rdata_q      <= '0;
    end else begin
      selected_q   <= selected_d;
      r0_value_q   <= r0_value_d;
      r0_valid_q   <= r0_valid_d;
      r0_en_q      <= r0_en_d;
      beat_q       <= beat_d;
      prog_len_q   <= prog_len_d;
      ovf_q        <= ovf_d;
      proto_err_q  <= proto_err_d;
      core_ready_q <= core_ready_d;
      rdata_q      <= rdata_d;
    end
  end

  // Write uses the pre-increment length as the address; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (ibuf_we) ibuf_mem[prog_len_q[AW-1:0]] <= mess[INSTR_SIZE-1:0];
  end

  assign sched.core_ready = core_ready_q;
  assign ibuf_rdata       = rdata_q;
  assign selected         = selected_q;
  assign r0_value         = r0_value_q;
  assign r0_valid         = r0_valid_q;
  assign prog_len         = prog_len_q;
  assign ovf              = ovf_q;
  assign proto_err        = proto_err_q;
endmodule

// File: tb/tb_core_msg_rx.sv
// Bench for core_msg_rx: two instances (core 5 / 256-deep, core 10 / 16-deep) on one shared
// message stream, checked every cycle against a task-level model plus directed literal checks.
module tb_core_msg_rx;
  localparam logic [3:0] NONE = 4'b0000, CM = 4'b1000, RM = 4'b0100, R0 = 4'b0010, IFS = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec_done;
  logic [7:0]  raddr;
  logic [15:0] rd0, rd1;
  logic        sel0, sel1, r0v0, r0v1, es0, es1, ovf0, ovf1, pe0, pe1;
  logic [7:0]  r0val0, r0val1;
  logic [8:0]  pl0;
  logic [4:0]  pl1;

  core_msg_rx_if #(.BUS_TO_CORE(16)) bus0 ();
  core_msg_rx_if #(.BUS_TO_CORE(16)) bus1 ();
  assign bus1.mess_to_core      = bus0.mess_to_core;
  assign bus1.core_mask_loading = bus0.core_mask_loading;
  assign bus1.r0_mask_loading   = bus0.r0_mask_loading;
  assign bus1.r0_loading        = bus0.r0_loading;
  assign bus1.if_loading        = bus0.if_loading;

  core_msg_rx #(.CORE_ID(5), .IBUF_DEPTH(256)) dut0 (
    .clk(clk), .reset(rst_n), .sched(bus0), .exec_done(exec_done), .ibuf_raddr(raddr),
    .ibuf_rdata(rd0), .selected(sel0), .r0_value(r0val0), .r0_valid(r0v0), .prog_len(pl0),
    .exec_start(es0), .ovf(ovf0), .proto_err(pe0));

  core_msg_rx #(.CORE_ID(10), .IBUF_DEPTH(16)) dut1 (
    .clk(clk), .reset(rst_n), .sched(bus1), .exec_done(exec_done), .ibuf_raddr(raddr[3:0]),
    .ibuf_rdata(rd1), .selected(sel1), .r0_value(r0val1), .r0_valid(r0v1), .prog_len(pl1),
    .exec_start(es1), .ovf(ovf1), .proto_err(pe1));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int es_cnt0 = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- task-level reference model ----------------
  typedef enum {P_IDLE, P_SEL, P_R0, P_LOAD, P_RUN} phase_t;
  phase_t      m_ph [2];
  int          m_cid [2] = '{5, 10};
  int          m_dep [2] = '{256, 16};
  bit          m_sel [2], m_r0v [2], m_ovf [2], m_perr [2], m_ready [2], m_r0en [2], m_rk [2];
  int          m_r0val [2], m_beat [2], m_len [2], m_rexp [2];
  logic [15:0] m_buf [2][256];

  task automatic model_reset(int i);
    m_ph[i] = P_IDLE; m_sel[i] = 0; m_r0v[i] = 0; m_ovf[i] = 0; m_perr[i] = 0;
    m_ready[i] = 1; m_r0en[i] = 0; m_r0val[i] = 0; m_beat[i] = 0; m_len[i] = 0;
    m_rk[i] = 1; m_rexp[i] = 0;
  endtask

  task automatic push(int i, logic [15:0] w);
    if (m_len[i] < m_dep[i]) begin
      m_buf[i][m_len[i]] = w;
      m_len[i]++;
    end else m_ovf[i] = 1;
  endtask

  task automatic model_step(int i);
    bit cm, rm, r, f, me;
    logic [15:0] msg;
    int a;
    cm = bus0.core_mask_loading; rm = bus0.r0_mask_loading;
    r = bus0.r0_loading; f = bus0.if_loading;
    msg = bus0.mess_to_core; me = msg[m_cid[i]];
    a = int'(raddr) % m_dep[i];
    m_rk[i] = (a < m_len[i]);
    m_rexp[i] = m_rk[i] ? int'(m_buf[i][a]) : 0;
    if (int'(cm) + int'(rm) + int'(r) + int'(f) > 1) m_perr[i] = 1;
    case (m_ph[i])
      P_IDLE: if (cm && me) begin m_ph[i] = P_SEL; m_sel[i] = 1; m_r0v[i] = 0; m_len[i] = 0; end
      P_SEL: begin
        if (cm) begin
          if (me) begin m_r0v[i] = 0; m_len[i] = 0; end
          else begin m_ph[i] = P_IDLE; m_sel[i] = 0; end
        end else if (rm) begin m_r0en[i] = me; m_beat[i] = 0; m_ph[i] = P_R0; end
        else if (r) m_perr[i] = 1;
        else if (f) begin push(i, msg); m_ph[i] = P_LOAD; end
      end
      P_R0: begin
        if (cm || rm) m_perr[i] = 1;
        else if (r) begin
          if (m_r0en[i] && m_beat[i] == m_cid[i] / 2) begin
            m_r0val[i] = (m_cid[i] % 2 == 1) ? int'(msg[15:8]) : int'(msg[7:0]);
            m_r0v[i] = 1;
          end
          m_beat[i]++;
        end else if (f) begin push(i, msg); m_ph[i] = P_LOAD; end
      end
      P_LOAD: begin
        if (!f) begin
          m_ph[i] = P_RUN; m_ready[i] = 0;
          if (cm || rm || r) m_perr[i] = 1;
        end else if (cm || rm || r) m_perr[i] = 1;
        else push(i, msg);
      end
      P_RUN: begin
        if (cm || rm || r || f) m_perr[i] = 1;
        if (exec_done) begin m_ph[i] = P_IDLE; m_ready[i] = 1; m_sel[i] = 0; end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin model_reset(0); model_reset(1); end
    else begin model_step(0); model_step(1); end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (es0) es_cnt0++;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("core_ready[%0d]", i), i ? int'(bus1.core_ready) : int'(bus0.core_ready), int'(m_ready[i]));
        chk($sformatf("selected[%0d]", i), i ? int'(sel1) : int'(sel0), int'(m_sel[i]));
        chk($sformatf("r0_valid[%0d]", i), i ? int'(r0v1) : int'(r0v0), int'(m_r0v[i]));
        chk($sformatf("r0_value[%0d]", i), i ? int'(r0val1) : int'(r0val0), m_r0val[i]);
        chk($sformatf("prog_len[%0d]", i), i ? int'(pl1) : int'(pl0), m_len[i]);
        chk($sformatf("exec_start[%0d]", i), i ? int'(es1) : int'(es0),
            int'(m_ph[i] == P_LOAD && !bus0.if_loading));
        chk($sformatf("ovf[%0d]", i), i ? int'(ovf1) : int'(ovf0), int'(m_ovf[i]));
        chk($sformatf("proto_err[%0d]", i), i ? int'(pe1) : int'(pe0), int'(m_perr[i]));
        if (m_rk[i]) chk($sformatf("ibuf_rdata[%0d]", i), i ? int'(rd1) : int'(rd0), m_rexp[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(logic [3:0] sb, logic [15:0] m, int ra, bit done);
    bus0.core_mask_loading = sb[3];
    bus0.r0_mask_loading   = sb[2];
    bus0.r0_loading        = sb[1];
    bus0.if_loading        = sb[0];
    bus0.mess_to_core      = m;
    exec_done              = done;
    raddr = (ra < 0) ? 8'($urandom_range(0, 255)) : 8'(ra);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] sb, logic [15:0] m, int ra = -1, bit done = 0);
    put(sb, m, ra, done);
    step();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(NONE, 16'($urandom));
  endtask

  logic [15:0] r0w [8] = '{16'h1111, 16'h2222, 16'hAB33, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};

  initial begin
    logic [15:0] m;
    logic [3:0]  sb;
    rst_n = 1'b0;
    put(NONE, 16'h0, 0, 0);
    #12;
    chk("reset core_ready", int'(bus0.core_ready), 1);
    chk("reset selected", int'(sel0), 0);
    chk("reset prog_len", int'(pl0), 0);
    chk("reset exec_start", int'(es0), 0);
    chk("reset proto_err", int'(pe0), 0);
    chk("reset ibuf_rdata", int'(rd0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Deselection: core 5 bit clear for a whole task.
    drive(CM, 16'h0010);
    drive(RM, 16'h0010);
    for (int k = 0; k < 8; k++) drive(R0, 16'($urandom));
    for (int k = 0; k < 4; k++) drive(IFS, 16'($urandom));
    idle(3);
    chk("desel selected", int'(sel0), 0);
    chk("desel core_ready", int'(bus0.core_ready), 1);
    chk("desel prog_len", int'(pl0), 0);
    chk("desel exec_start count", es_cnt0, 0);

    // Selection, r0 capture on beat 2 high byte, 32-word program, run.
    drive(CM, 16'h0020);
    chk("sel selected", int'(sel0), 1);
    drive(RM, 16'h0020);
    for (int k = 0; k < 8; k++) drive(R0, r0w[k]);
    chk("r0 value", int'(r0val0), 'hAB);
    chk("r0 valid", int'(r0v0), 1);
    for (int k = 0; k < 32; k++) drive(IFS, 16'(16'h0100 + k));
    put(NONE, 16'h0, -1, 0);
    #2;
    chk("exec_start pulse", int'(es0), 1);
    step();
    chk("exec_start width", int'(es0), 0);
    chk("run core_ready", int'(bus0.core_ready), 0);
    chk("run prog_len", int'(pl0), 32);
    drive(NONE, 16'h0, 3);
    chk("ibuf read 3", int'(rd0), 'h0103);
    drive(NONE, 16'h0, -1, 1);
    chk("done core_ready", int'(bus0.core_ready), 1);
    chk("done selected", int'(sel0), 0);
    chk("exec_start count", es_cnt0, 1);

    // Overflow on the 16-deep core 10.
    drive(CM, 16'h0400);
    drive(RM, 16'h0400);
    for (int k = 0; k < 8; k++) drive(R0, 16'($urandom));
    for (int k = 0; k < 20; k++) drive(IFS, 16'(16'h0200 + k));
    idle(1);
    chk("ovf prog_len", int'(pl1), 16);
    chk("ovf flag", int'(ovf1), 1);
    chk("ovf other core", int'(ovf0), 0);
    drive(NONE, 16'h0, 15);
    chk("ovf last word", int'(rd1), 'h020F);
    drive(NONE, 16'h0, -1, 1);

    // Strobe while running.
    drive(CM, 16'h0020);
    for (int k = 0; k < 4; k++) drive(IFS, 16'(16'h0300 + k));
    idle(2);
    drive(CM, 16'h0020);
    chk("run strobe proto_err", int'(pe0), 1);
    chk("run strobe core_ready", int'(bus0.core_ready), 0);
    chk("run strobe prog_len", int'(pl0), 4);
    drive(NONE, 16'h0, -1, 1);

    // Asynchronous reset in the middle of a program load.
    drive(CM, 16'h0420);
    for (int k = 0; k < 5; k++) drive(IFS, 16'(16'h0700 + k));
    put(IFS, 16'h0705, -1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset core_ready", int'(bus0.core_ready), 1);
    chk("areset selected", int'(sel0), 0);
    chk("areset prog_len", int'(pl0), 0);
    chk("areset r0_value", int'(r0val0), 0);
    chk("areset proto_err", int'(pe0), 0);
    chk("areset ibuf_rdata", int'(rd0), 0);
    chk("areset ovf", int'(ovf1), 0);
    put(NONE, 16'h0, -1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(CM, 16'h0420);
    drive(RM, 16'h0420);
    for (int k = 0; k < 8; k++) drive(R0, 16'({8'(8'hA0 + k), 8'(8'h50 + k)}));
    for (int k = 0; k < 10; k++) drive(IFS, 16'(16'h0800 + k));
    idle(1);
    chk("reload prog_len0", int'(pl0), 10);
    chk("reload prog_len1", int'(pl1), 10);
    chk("reload r0_value0", int'(r0val0), 'hA2);
    chk("reload r0_value1", int'(r0val1), 'h55);
    drive(NONE, 16'h0, -1, 1);

    // Mask and instruction strobe together: mask wins.
    drive(CM | IFS, 16'h0020);
    chk("dual selected", int'(sel0), 1);
    chk("dual proto_err", int'(pe0), 1);
    chk("dual prog_len", int'(pl0), 0);
    for (int k = 0; k < 3; k++) drive(IFS, 16'($urandom));
    idle(1);
    drive(NONE, 16'h0, -1, 1);

    // Randomized tasks; late ones carry occasional extra strobes.
    for (int t = 0; t < 40; t++) begin
      m = 16'($urandom);
      if ($urandom_range(0, 2) == 0) m[5] = 1'b1;
      if ($urandom_range(0, 2) == 0) m[10] = 1'b1;
      drive(CM, m);
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        drive(RM, 16'($urandom));
        idle($urandom_range(0, 2));
        for (int k = 0; k < int'($urandom_range(0, 10)); k++) drive(R0, 16'($urandom));
      end
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
        sb = IFS;
        if (t >= 30 && $urandom_range(0, 19) == 0) sb[$urandom_range(1, 3)] = 1'b1;
        drive(sb, 16'($urandom));
      end
      idle($urandom_range(1, 4));
      drive(NONE, 16'($urandom), -1, 1);
      idle(1);
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/core_msg_rx.md
Name: core_msg_rx

Overview:
- Per-core receive stage directly downstream of the task scheduler; one instance per core, identified by CORE_ID.
- Consumes the 16-bit scheduler message bus and its four loading strobes.
- Decides whether this core is selected, extracts its r0 byte, and buffers the instruction stream.
- Starts execution and drives this core's bit of the scheduler's core_ready vector.

Parameters:
- CORE_ID, 0, index of this core in the 16-bit masks (0..15).
- BUS_TO_CORE, 16, message bus width.
- INSTR_SIZE, 16, instruction word width.
- R0_DEPTH, 8, r0 data beats per task (16 cores x 8 bits = 128 bits).
- IBUF_DEPTH, 256, instruction buffer entries (power of two).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- mess_to_core  in  BUS_TO_CORE  message word from scheduler.
- core_mask_loading  in  1  bus carries the execution mask this cycle.
- r0_mask_loading  in  1  bus carries the r0 init vector this cycle.
- r0_loading  in  1  bus carries an r0 data word this cycle.
- if_loading  in  1  bus carries an instruction word this cycle.
- exec_done  in  1  one-cycle pulse from the core pipeline: program finished.
- ibuf_raddr  in  log2(IBUF_DEPTH)  core fetch address.
- ibuf_rdata  out  INSTR_SIZE  instruction at ibuf_raddr; registered, 1-cycle latency.
- core_ready  out  1  1 = idle/available; goes to scheduler core_ready[CORE_ID].
- selected  out  1  this core is a target of the current task.
- r0_value  out  8  r0 init byte for this core.
- r0_valid  out  1  r0_value written for the current task.
- prog_len  out  log2(IBUF_DEPTH)+1  number of instruction words stored.
- exec_start  out  1  one-cycle pulse: program ready, begin fetch at 0.
- ovf  out  1  sticky: instruction words dropped because the buffer was full.
- proto_err  out  1  sticky: a strobe arrived in an illegal state.

Behaviour:
- Reset (reset=0, asynchronous):
  - outputs: core_ready=1; selected=0, r0_value=0, r0_valid=0, prog_len=0, exec_start=0, ovf=0, proto_err=0, ibuf_rdata=0.
  - state IDLE; beat and write counters 0; buffer contents undefined.
  - A reset mid-task abandons the task, including a partially written buffer.
- Strobe priority when several are high in one cycle: core_mask > r0_mask > r0 > if. Lower-priority strobes in that cycle are ignored and set proto_err.
- FSM states: IDLE, SEL, R0, IFL, RUN.
- IDLE:
  - core_mask_loading with mess_to_core[CORE_ID]=1: go to SEL; selected=1; clear r0_valid, prog_len and write pointer.
  - core_mask_loading with bit clear: stay IDLE; all other strobes ignored silently.
- SEL:
  - r0_mask_loading: latch r0_en = mess_to_core[CORE_ID]; go to R0; beat counter = 0.
  - if_loading: skip r0 and go to IFL, treating that beat as instruction word 0.
  - core_mask_loading: re-evaluate the selection as in IDLE.
- R0:
  - Each r0_loading beat increments the beat counter.
  - On beat CORE_ID>>1 with r0_en=1: r0_value = CORE_ID[0] ? mess[15:8] : mess[7:0]; r0_valid=1.
  - Beats at or beyond R0_DEPTH are ignored.
  - if_loading moves to IFL and that beat is written.
- IFL:
  - Each if_loading beat writes mess_to_core to ibuf[wptr]; wptr and prog_len increment.
  - When prog_len == IBUF_DEPTH, further beats are dropped (no wrap) and ovf=1.
  - First cycle with if_loading=0 after at least one beat: go to RUN; exec_start=1 for exactly one cycle; core_ready=0 registered in that same cycle.
- RUN:
  - core_ready=0.
  - exec_done: go to IDLE; core_ready=1 next cycle; selected=0.
  - Any strobe in RUN is ignored and sets proto_err. The scheduler must never select a busy core.
- exec_done outside RUN is ignored.
- core_ready is fully registered, with no combinational path from the inputs.
- ibuf: single write port and single read port. A read of the address being written in the same cycle returns the old data.

Test Plan:
- Selection and r0 capture (CORE_ID=5): core_mask 0x0020, r0_mask 0x0020, r0 beats 0x1111,0x2222,0xAB33,… → selected=1, r0_value=0xAB, r0_valid=1.
- Deselection (CORE_ID=5): core_mask 0x0010, followed by a full task → selected=0, core_ready stays 1, prog_len=0, no exec_start.
- Program load and run: selected core, 32 if beats 0x0100..0x011F → one exec_start pulse the cycle after the last beat; prog_len=32; core_ready=0; ibuf_raddr=3 gives 0x0103 one cycle later; exec_done → core_ready=1 next cycle.
- Overflow (IBUF_DEPTH=16): 20 if beats → prog_len=16, ovf=1, ibuf[15] holds beat 15.
- Protocol errors: core_mask_loading in RUN → proto_err=1, state unchanged; core_mask and if_loading in the same cycle → mask handled, proto_err=1.
- Asynchronous reset: drop reset mid-IFL, off a clock edge → core_ready=1 and all other outputs 0 immediately; the next full task loads correctly.
